// File: rtl/spi_slave_port_if.sv
// spi_slave_port_if: SPI pins plus host WRITE/READ strobe bundle for spi_slave_port.
// master = initiator/host side, slave = the responder.
interface spi_slave_port_if #(
    parameter int WIDTH = 8
);
    logic             SCLK;
    logic             SS_N;
    logic             MOSI;
    logic             MISO;
    logic [WIDTH-1:0] DATA_IN;
    logic             WRITE;
    logic             READ;
    logic [WIDTH-1:0] DATA_OUT;
    logic             TX_FULL_STATE;
    logic             RX_FULL_STATE;
    logic             BUSY;
    logic             OVERRUN;

    modport master (
        output SCLK, SS_N, MOSI, DATA_IN, WRITE, READ,
        input  MISO, DATA_OUT, TX_FULL_STATE, RX_FULL_STATE, BUSY, OVERRUN
    );

    modport slave (
        input  SCLK, SS_N, MOSI, DATA_IN, WRITE, READ,
        output MISO, DATA_OUT, TX_FULL_STATE, RX_FULL_STATE, BUSY, OVERRUN
    );
endinterface

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI mode-0 responder with one-byte TX/RX buffers.
// Define SPI_SLAVE_OVERRUN_EN to drop bytes arriving while RX is unread and flag OVERRUN.
module spi_slave_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic             CLK,
    input logic             CLR,
    spi_slave_port_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_d;
    logic                   ss_d;
    logic [WIDTH-1:0]       tx_buf;
    logic [WIDTH-1:0]       tx_shift;
    logic [WIDTH-1:0]       rx_shift;
    logic [WIDTH-1:0]       data_out;
    logic [CW-1:0]          bit_cnt;
    logic                   tx_full;
    logic                   rx_full;
    logic                   busy;
    logic                   done;
    logic                   reload;

    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_fall;
    logic                   ss_rise;
    logic                   load;
    logic [WIDTH-1:0]       load_val;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign ss_s      = ss_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    // A load takes the TX buffer at frame start and at the fall after each full byte.
    assign load = (state == IDLE && ss_fall) ||
                  (state == ACTIVE && !ss_rise && sclk_fall && reload);
    assign load_val = tx_full ? tx_buf : '0;

    assign bus.MISO          = tx_shift[WIDTH-1];
    assign bus.DATA_OUT      = data_out;
    assign bus.TX_FULL_STATE = tx_full;
    assign bus.RX_FULL_STATE = rx_full;
    assign bus.BUSY          = busy;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun;
    assign bus.OVERRUN = overrun;
`else
    assign bus.OVERRUN = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            // SS_N sync clears to "low" so a frame in flight cannot be joined.
            sclk_q   <= '0;
            ss_q     <= '0;
            mosi_q   <= '0;
            sclk_d   <= 1'b0;
            ss_d     <= 1'b0;
            tx_buf   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            data_out <= '0;
            bit_cnt  <= '0;
            tx_full  <= 1'b0;
            rx_full  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            reload   <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            overrun  <= 1'b0;
`endif
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.SCLK};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], bus.SS_N};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.MOSI};
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
            done   <= 1'b0;

            if (bus.WRITE && (load || !tx_full)) begin
                tx_buf  <= bus.DATA_IN;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= ACTIVE;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        reload   <= 1'b0;
                        tx_shift <= load_val;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        bit_cnt  <= '0;
                        reload   <= 1'b0;
                        tx_shift <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            bit_cnt <= '0;
                            done    <= 1'b1;
                            reload  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (reload) begin
                            tx_shift <= load_val;
                            reload   <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion outranks a coincident READ.
            if (done) begin
`ifdef SPI_SLAVE_OVERRUN_EN
                if (rx_full && !bus.READ) begin
                    overrun <= 1'b1;
                end else begin
                    data_out <= rx_shift;
                end
`else
                data_out <= rx_shift;
`endif
                rx_full <= 1'b1;
            end else if (bus.READ) begin
                rx_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed and random frames against a byte-level model.
// Honours SPI_SLAVE_OVERRUN_EN the same way the design does.
module tb_spi_slave_port;
    localparam int WIDTH = 8;
    localparam int HALF  = 6;

    logic CLK = 1'b0;
    logic CLR;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    spi_slave_port_if #(.WIDTH(WIDTH)) bus ();

    spi_slave_port #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(2)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .bus(bus)
    );

    // Byte-level reference state
    logic [7:0] m_buf;
    logic       m_txf;
    logic       m_rxf;
    logic [7:0] m_dout;
    logic       m_ovr;
    logic [7:0] cur;
    logic [7:0] mo [4];
    logic [7:0] miso_cap;

    task automatic wait_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_buf  = 8'h00;
        m_txf  = 1'b0;
        m_rxf  = 1'b0;
        m_dout = 8'h00;
        m_ovr  = 1'b0;
        cur    = 8'h00;
    endtask

    task automatic model_load();
        cur   = m_txf ? m_buf : 8'h00;
        m_txf = 1'b0;
    endtask

    task automatic model_complete(input logic [7:0] b);
`ifdef SPI_SLAVE_OVERRUN_EN
        if (m_rxf) m_ovr = 1'b1;
        else m_dout = b;
`else
        m_dout = b;
`endif
        m_rxf = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, bus.DATA_OUT, m_dout);
        chk({tag, ".rxf"}, {7'd0, bus.RX_FULL_STATE}, {7'd0, m_rxf});
        chk({tag, ".txf"}, {7'd0, bus.TX_FULL_STATE}, {7'd0, m_txf});
        chk({tag, ".ovr"}, {7'd0, bus.OVERRUN}, {7'd0, m_ovr});
    endtask

    task automatic host_write(input logic [7:0] d);
        bus.DATA_IN = d;
        bus.WRITE   = 1'b1;
        wait_n(1);
        bus.WRITE   = 1'b0;
        if (!m_txf) begin
            m_buf = d;
            m_txf = 1'b1;
        end
        wait_n(1);
        chk("write.txf", {7'd0, bus.TX_FULL_STATE}, {7'd0, m_txf});
    endtask

    task automatic host_read();
        bus.READ = 1'b1;
        wait_n(1);
        bus.READ = 1'b0;
        m_rxf    = 1'b0;
        wait_n(1);
        chk("read.rxf", {7'd0, bus.RX_FULL_STATE}, {7'd0, m_rxf});
        chk("read.dout", bus.DATA_OUT, m_dout);
    endtask

    // nbytes frames under one SS_N; the last one stops after last_bits bits.
    task automatic spi_xfer(input int nbytes, input int last_bits);
        logic [7:0] got;
        int         nb;
        bus.SS_N = 1'b0;
        model_load();
        wait_n(HALF);
        chk("xfer.busy", {7'd0, bus.BUSY}, 8'd1);
        for (int b = 0; b < nbytes; b++) begin
            nb  = (b == nbytes - 1) ? last_bits : 8;
            got = 8'h00;
            for (int i = 0; i < nb; i++) begin
                got[7-i] = bus.MISO;
                chk("xfer.miso", {7'd0, bus.MISO}, {7'd0, cur[7-i]});
                bus.MOSI = mo[b][7-i];
                wait_n(HALF);
                bus.SCLK = 1'b1;
                wait_n(HALF);
                if (i == 7) begin
                    model_complete(mo[b]);
                    chk("byte.dout", bus.DATA_OUT, m_dout);
                    chk("byte.rxf", {7'd0, bus.RX_FULL_STATE}, {7'd0, m_rxf});
                    chk("byte.ovr", {7'd0, bus.OVERRUN}, {7'd0, m_ovr});
                end
                bus.SCLK = 1'b0;
                if (i == 7) model_load();
                wait_n(HALF);
            end
            if (b == 0) miso_cap = got;
        end
        bus.SS_N = 1'b1;
        bus.MOSI = 1'b0;
        wait_n(HALF);
        chk("end.busy", {7'd0, bus.BUSY}, 8'd0);
        chk("end.miso", {7'd0, bus.MISO}, 8'd0);
        check_all("end");
    endtask

    task automatic sclk_pulse();
        wait_n(HALF);
        bus.SCLK = 1'b1;
        wait_n(HALF);
        bus.SCLK = 1'b0;
        wait_n(HALF);
    endtask

    initial begin
        bus.SCLK    = 1'b0;
        bus.SS_N    = 1'b1;
        bus.MOSI    = 1'b0;
        bus.DATA_IN = 8'h00;
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        CLR         = 1'b1;
        model_reset();
        wait_n(3);
        CLR = 1'b0;
        wait_n(4);
        chk("rst.busy", {7'd0, bus.BUSY}, 8'd0);
        chk("rst.miso", {7'd0, bus.MISO}, 8'd0);
        check_all("rst");

        // Loaded TX byte, full duplex
        host_write(8'hA5);
        mo[0] = 8'h62;
        spi_xfer(1, 8);
        chk("t2.miso", miso_cap, 8'hA5);
        chk("t2.dout", bus.DATA_OUT, 8'h62);

        // Underrun sends zeros
        host_read();
        mo[0] = 8'h3C;
        spi_xfer(1, 8);
        chk("t3.miso", miso_cap, 8'h00);
        host_read();
        chk("t3.dout", bus.DATA_OUT, 8'h3C);

        // Aborted frame
        mo[0] = 8'hFF;
        spi_xfer(1, 5);
        chk("t4.dout", bus.DATA_OUT, 8'h3C);

        // Back-to-back frames without READ
        mo[0] = 8'h11;
        mo[1] = 8'h22;
        spi_xfer(2, 8);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("t5.dout", bus.DATA_OUT, 8'h11);
        chk("t5.ovr", {7'd0, bus.OVERRUN}, 8'd1);
`else
        chk("t5.dout", bus.DATA_OUT, 8'h22);
        chk("t5.ovr", {7'd0, bus.OVERRUN}, 8'd0);
`endif

        // CLR in the middle of a frame
        host_write(8'h77);
        bus.SS_N = 1'b0;
        model_load();
        wait_n(HALF);
        bus.MOSI = 1'b1;
        for (int i = 0; i < 3; i++) sclk_pulse();
        CLR = 1'b1;
        wait_n(1);
        CLR = 1'b0;
        model_reset();
        chk("t1.busy", {7'd0, bus.BUSY}, 8'd0);
        chk("t1.miso", {7'd0, bus.MISO}, 8'd0);
        check_all("t1");
        for (int i = 0; i < 5; i++) begin
            sclk_pulse();
            chk("t1.idle_busy", {7'd0, bus.BUSY}, 8'd0);
            chk("t1.idle_miso", {7'd0, bus.MISO}, 8'd0);
        end
        check_all("t1.after");
        bus.SS_N = 1'b1;
        bus.MOSI = 1'b0;
        wait_n(HALF);

        // Second WRITE while full is ignored
        host_write(8'hC3);
        host_write(8'h5A);
        mo[0] = 8'h99;
        spi_xfer(1, 8);
        chk("t6.miso", miso_cap, 8'hC3);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            int nbytes;
            int last;
            if ($urandom_range(1, 0) == 1) host_write(8'($urandom));
            if ($urandom_range(2, 0) == 0) host_read();
            nbytes = int'($urandom_range(2, 1));
            last   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(7, 1)) : 8;
            for (int b = 0; b < 4; b++) mo[b] = 8'($urandom);
            spi_xfer(nbytes, last);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
